// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline from decode through EX, MEM and WB.
// Also detects load-use hazards and turns dead slots into bubbles.
module ctrl_pipe #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic              id_illegal_i,
   input  logic              id_a_sel_i,
   input  logic              id_b_sel_i,
   input  logic [3:0]        id_alu_sel_i,
   input  logic              id_memRW_i,
   input  logic [1:0]        id_dataIn_i,
   input  logic [2:0]        id_dataOutAddj_i,
   input  logic              id_regWEn_i,
   input  logic [1:0]        id_wb_sel_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   output logic              stall_o,
   output logic              ex_valid_o,
   output logic              ex_a_sel_o,
   output logic              ex_b_sel_o,
   output logic [3:0]        ex_alu_sel_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              mem_valid_o,
   output logic              mem_memRW_o,
   output logic [1:0]        mem_dataIn_o,
   output logic [2:0]        mem_dataOutAddj_o,
   output logic [REG_AW-1:0] mem_rd_o,
   output logic              wb_valid_o,
   output logic              wb_regWEn_o,
   output logic [1:0]        wb_wb_sel_o,
   output logic [REG_AW-1:0] wb_rd_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic              ex_valid, ex_a_sel, ex_b_sel, ex_memRW, ex_regWEn;
   logic [3:0]        ex_alu_sel;
   logic [1:0]        ex_dataIn, ex_wb_sel;
   logic [2:0]        ex_dataOutAddj;
   logic [REG_AW-1:0] ex_rd;

   logic              mem_valid, mem_memRW, mem_regWEn;
   logic [1:0]        mem_dataIn, mem_wb_sel;
   logic [2:0]        mem_dataOutAddj;
   logic [REG_AW-1:0] mem_rd;

   logic              wb_valid, wb_regWEn;
   logic [1:0]        wb_wb_sel;
   logic [REG_AW-1:0] wb_rd;

   logic              illegal_q;
   logic [CNT_W-1:0]  bubble_cnt;

   logic load_use, ex_bubble, cnt_inc;

   // Only a load (wb_sel 00) in EX to a non-zero register can hazard.
   always_comb begin
      load_use = ex_valid & ex_regWEn & (ex_wb_sel == 2'b00) & (ex_rd != '0) & id_valid_i &
                 ((id_use_rs1_i & (id_rs1_i == ex_rd)) | (id_use_rs2_i & (id_rs2_i == ex_rd)));
      stall_o   = load_use & ~flush_i & ~hold_i;
      ex_bubble = flush_i | ~id_valid_i | id_illegal_i | load_use;
      cnt_inc   = load_use | id_illegal_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid        <= 1'b0;
         ex_a_sel        <= 1'b0;
         ex_b_sel        <= 1'b0;
         ex_alu_sel      <= '0;
         ex_memRW        <= 1'b0;
         ex_dataIn       <= '0;
         ex_dataOutAddj  <= '0;
         ex_regWEn       <= 1'b0;
         ex_wb_sel       <= '0;
         ex_rd           <= '0;
         mem_valid       <= 1'b0;
         mem_memRW       <= 1'b0;
         mem_dataIn      <= '0;
         mem_dataOutAddj <= '0;
         mem_regWEn      <= 1'b0;
         mem_wb_sel      <= '0;
         mem_rd          <= '0;
         wb_valid        <= 1'b0;
         wb_regWEn       <= 1'b0;
         wb_wb_sel       <= '0;
         wb_rd           <= '0;
         illegal_q       <= 1'b0;
         bubble_cnt      <= '0;
      end else if (hold_i) begin
         illegal_q <= 1'b0;
      end else begin
         wb_valid        <= mem_valid;
         wb_regWEn       <= mem_regWEn;
         wb_wb_sel       <= mem_wb_sel;
         wb_rd           <= mem_rd;
         mem_valid       <= ex_valid;
         mem_memRW       <= ex_memRW;
         mem_dataIn      <= ex_dataIn;
         mem_dataOutAddj <= ex_dataOutAddj;
         mem_regWEn      <= ex_regWEn;
         mem_wb_sel      <= ex_wb_sel;
         mem_rd          <= ex_rd;
         // Bubbles load constants so X on a dead ID slot never propagates.
         if (ex_bubble) begin
            ex_valid       <= 1'b0;
            ex_a_sel       <= 1'b0;
            ex_b_sel       <= 1'b0;
            ex_alu_sel     <= '0;
            ex_memRW       <= 1'b0;
            ex_dataIn      <= '0;
            ex_dataOutAddj <= '0;
            ex_regWEn      <= 1'b0;
            ex_wb_sel      <= '0;
            ex_rd          <= '0;
         end else begin
            ex_valid       <= 1'b1;
            ex_a_sel       <= id_a_sel_i;
            ex_b_sel       <= id_b_sel_i;
            ex_alu_sel     <= id_alu_sel_i;
            ex_memRW       <= id_memRW_i;
            ex_dataIn      <= id_dataIn_i;
            ex_dataOutAddj <= id_dataOutAddj_i;
            ex_regWEn      <= id_regWEn_i;
            ex_wb_sel      <= id_wb_sel_i;
            ex_rd          <= id_rd_i;
         end
         illegal_q <= id_valid_i & id_illegal_i & ~flush_i;
         if (cnt_inc && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

   assign ex_valid_o        = ex_valid;
   assign ex_a_sel_o        = ex_a_sel;
   assign ex_b_sel_o        = ex_b_sel;
   assign ex_alu_sel_o      = ex_alu_sel;
   assign ex_rd_o           = ex_rd;
   assign mem_valid_o       = mem_valid;
   assign mem_memRW_o       = mem_valid & mem_memRW;
   assign mem_dataIn_o      = mem_dataIn;
   assign mem_dataOutAddj_o = mem_dataOutAddj;
   assign mem_rd_o          = mem_rd;
   assign wb_valid_o        = wb_valid;
   assign wb_regWEn_o       = wb_valid & wb_regWEn;
   assign wb_wb_sel_o       = wb_wb_sel;
   assign wb_rd_o           = wb_rd;
   assign illegal_o         = illegal_q;
   assign bubble_cnt_o      = bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; counter narrowed to 4 bits so saturation is reachable quickly.
module tb_ctrl_pipe;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic clk, rst_n, hold_i, flush_i;
   logic id_valid_i, id_illegal_i, id_a_sel_i, id_b_sel_i, id_memRW_i, id_regWEn_i;
   logic id_use_rs1_i, id_use_rs2_i;
   logic [3:0] id_alu_sel_i;
   logic [1:0] id_dataIn_i, id_wb_sel_i;
   logic [2:0] id_dataOutAddj_i;
   logic [REG_AW-1:0] id_rd_i, id_rs1_i, id_rs2_i;

   logic stall_o, ex_valid_o, ex_a_sel_o, ex_b_sel_o, mem_valid_o, mem_memRW_o;
   logic wb_valid_o, wb_regWEn_o, illegal_o;
   logic [3:0] ex_alu_sel_o;
   logic [1:0] mem_dataIn_o, wb_wb_sel_o;
   logic [2:0] mem_dataOutAddj_o;
   logic [REG_AW-1:0] ex_rd_o, mem_rd_o, wb_rd_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   ctrl_pipe #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_illegal_i(id_illegal_i),
      .id_a_sel_i(id_a_sel_i), .id_b_sel_i(id_b_sel_i), .id_alu_sel_i(id_alu_sel_i),
      .id_memRW_i(id_memRW_i), .id_dataIn_i(id_dataIn_i), .id_dataOutAddj_i(id_dataOutAddj_i),
      .id_regWEn_i(id_regWEn_i), .id_wb_sel_i(id_wb_sel_i),
      .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
      .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_a_sel_o(ex_a_sel_o),
      .ex_b_sel_o(ex_b_sel_o), .ex_alu_sel_o(ex_alu_sel_o), .ex_rd_o(ex_rd_o),
      .mem_valid_o(mem_valid_o), .mem_memRW_o(mem_memRW_o), .mem_dataIn_o(mem_dataIn_o),
      .mem_dataOutAddj_o(mem_dataOutAddj_o), .mem_rd_o(mem_rd_o),
      .wb_valid_o(wb_valid_o), .wb_regWEn_o(wb_regWEn_o), .wb_wb_sel_o(wb_wb_sel_o),
      .wb_rd_o(wb_rd_o), .illegal_o(illegal_o), .bubble_cnt_o(bubble_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_clear();
      hold_i = 0; flush_i = 0;
      id_valid_i = 0; id_illegal_i = 0; id_a_sel_i = 0; id_b_sel_i = 0;
      id_alu_sel_i = 0; id_memRW_i = 0; id_dataIn_i = 0; id_dataOutAddj_i = 0;
      id_regWEn_i = 0; id_wb_sel_i = 0; id_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
      id_use_rs1_i = 0; id_use_rs2_i = 0;
   endtask

   task automatic drain();
      id_clear();
      repeat (3) tick();
   endtask

   task automatic set_load(input logic [4:0] rd);
      id_clear();
      id_valid_i = 1; id_regWEn_i = 1; id_wb_sel_i = 2'b00; id_rd_i = rd;
      id_dataOutAddj_i = 3'b010; id_use_rs1_i = 1; id_rs1_i = 5'd1;
   endtask

   task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1);
      id_clear();
      id_valid_i = 1; id_regWEn_i = 1; id_wb_sel_i = 2'b01; id_rd_i = rd;
      id_a_sel_i = 1; id_alu_sel_i = 4'h3; id_use_rs1_i = 1; id_rs1_i = rs1;
      id_use_rs2_i = 1; id_rs2_i = 5'd2;
   endtask

   task automatic set_store(input logic [1:0] size);
      id_clear();
      id_valid_i = 1; id_memRW_i = 1; id_dataIn_i = size; id_b_sel_i = 1;
      id_use_rs1_i = 1; id_rs1_i = 5'd3; id_use_rs2_i = 1; id_rs2_i = 5'd4;
   endtask

   initial begin
      // reset with random inputs
      rst_n = 0;
      id_clear();
      for (int i = 0; i < 4; i++) begin
         {hold_i, flush_i, id_valid_i, id_illegal_i, id_a_sel_i, id_b_sel_i, id_memRW_i,
          id_regWEn_i, id_use_rs1_i, id_use_rs2_i} = 10'($urandom);
         id_alu_sel_i = 4'($urandom); id_wb_sel_i = 2'($urandom);
         id_rd_i = 5'($urandom); id_rs1_i = 5'($urandom); id_rs2_i = 5'($urandom);
         tick();
      end
      check_eq("rst ex_valid", 32'(ex_valid_o), 0);
      check_eq("rst ex_alu", 32'(ex_alu_sel_o), 0);
      check_eq("rst mem_memRW", 32'(mem_memRW_o), 0);
      check_eq("rst wb_regWEn", 32'(wb_regWEn_o), 0);
      check_eq("rst wb_rd", 32'(wb_rd_o), 0);
      check_eq("rst illegal", 32'(illegal_o), 0);
      check_eq("rst cnt", 32'(bubble_cnt_o), 0);
      check_eq("rst stall", 32'(stall_o), 0);

      // ADD latency through EX/MEM/WB
      id_clear();
      @(negedge clk) rst_n = 1;
      set_add(5'd5, 5'd1);
      tick();
      check_eq("add ex_valid", 32'(ex_valid_o), 1);
      check_eq("add ex_rd", 32'(ex_rd_o), 5);
      check_eq("add ex_alu", 32'(ex_alu_sel_o), 3);
      check_eq("add ex_a_sel", 32'(ex_a_sel_o), 1);
      id_clear();
      tick();
      check_eq("add mem_valid", 32'(mem_valid_o), 1);
      check_eq("add mem_rd", 32'(mem_rd_o), 5);
      check_eq("add ex empty", 32'(ex_valid_o), 0);
      tick();
      check_eq("add wb_valid", 32'(wb_valid_o), 1);
      check_eq("add wb_regWEn", 32'(wb_regWEn_o), 1);
      check_eq("add wb_rd", 32'(wb_rd_o), 5);
      check_eq("add wb_sel", 32'(wb_wb_sel_o), 1);

      // load-use: one stall cycle, one bubble
      drain();
      set_load(5'd7);
      tick();
      set_add(5'd8, 5'd7);
      #1 check_eq("lu stall", 32'(stall_o), 1);
      tick();
      check_eq("lu ex bubble", 32'(ex_valid_o), 0);
      check_eq("lu cnt", 32'(bubble_cnt_o), 1);
      check_eq("lu mem load", 32'(mem_valid_o), 1);
      check_eq("lu mem adj", 32'(mem_dataOutAddj_o), 2);
      check_eq("lu stall cleared", 32'(stall_o), 0);
      tick();
      check_eq("lu add in ex", 32'(ex_valid_o), 1);
      check_eq("lu add rd", 32'(ex_rd_o), 8);

      // no-hazard variants
      drain();
      set_load(5'd0);
      tick();
      set_add(5'd9, 5'd0);
      #1 check_eq("x0 no stall", 32'(stall_o), 0);
      tick();
      check_eq("x0 ex_valid", 32'(ex_valid_o), 1);
      set_load(5'd7);
      tick();
      id_clear();
      id_valid_i = 1; id_regWEn_i = 1; id_wb_sel_i = 2'b01; id_rd_i = 5'd10;
      id_rs1_i = 5'd7; id_rs2_i = 5'd7;
      #1 check_eq("lui no stall", 32'(stall_o), 0);
      tick();
      check_eq("nohaz cnt", 32'(bubble_cnt_o), 1);

      // flushed store never strobes memory
      drain();
      set_store(2'b10);
      flush_i = 1;
      tick();
      check_eq("flush ex_valid", 32'(ex_valid_o), 0);
      id_clear();
      tick();
      check_eq("flush memRW 1", 32'(mem_memRW_o), 0);
      tick();
      check_eq("flush memRW 2", 32'(mem_memRW_o), 0);

      // hold freezes all stages with a store in MEM
      drain();
      set_store(2'b01);
      tick();
      id_clear();
      tick();
      check_eq("hold pre memRW", 32'(mem_memRW_o), 1);
      hold_i = 1;
      id_valid_i = 1; id_illegal_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("hold memRW", 32'(mem_memRW_o), 1);
         check_eq("hold dataIn", 32'(mem_dataIn_o), 1);
         check_eq("hold ex_valid", 32'(ex_valid_o), 0);
         check_eq("hold illegal", 32'(illegal_o), 0);
         check_eq("hold cnt", 32'(bubble_cnt_o), 1);
      end
      id_clear();
      tick();
      check_eq("resume wb_valid", 32'(wb_valid_o), 1);
      check_eq("resume wb_regWEn", 32'(wb_regWEn_o), 0);
      check_eq("resume memRW", 32'(mem_memRW_o), 0);

      // illegal pulse, bubble and saturating counter
      drain();
      set_add(5'd3, 5'd1);
      id_illegal_i = 1;
      tick();
      check_eq("ill pulse", 32'(illegal_o), 1);
      check_eq("ill ex bubble", 32'(ex_valid_o), 0);
      check_eq("ill cnt", 32'(bubble_cnt_o), 2);
      id_clear();
      tick();
      check_eq("ill pulse end", 32'(illegal_o), 0);
      set_add(5'd3, 5'd1);
      id_illegal_i = 1;
      repeat (20) tick();
      check_eq("cnt saturate", 32'(bubble_cnt_o), 15);

      // flush together with load-use
      drain();
      set_load(5'd9);
      tick();
      set_add(5'd11, 5'd9);
      flush_i = 1;
      #1 check_eq("flush lu stall", 32'(stall_o), 0);
      tick();
      check_eq("flush lu ex", 32'(ex_valid_o), 0);

      // reset mid-stall
      drain();
      set_load(5'd7);
      tick();
      set_add(5'd8, 5'd7);
      #1 check_eq("mid pre stall", 32'(stall_o), 1);
      rst_n = 0;
      #1;
      check_eq("mid stall", 32'(stall_o), 0);
      check_eq("mid ex_valid", 32'(ex_valid_o), 0);
      check_eq("mid mem_valid", 32'(mem_valid_o), 0);
      check_eq("mid cnt", 32'(bubble_cnt_o), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
